// File: rtl/lisa_qspi_arb.sv
// lisa_qspi_arb: shared QSPI controller for flash fetch and PSRAM data.
// Round-robin grant, board CE latch over dq[2:1], one 16-bit quad transfer.
module lisa_qspi_arb #(
  parameter int unsigned DUMMY_FLASH  = 6,
  parameter int unsigned DUMMY_PSRAM  = 6,
  parameter logic [7:0]  FLASH_RD_CMD = 8'hEB,
  parameter logic [7:0]  PSRAM_RD_CMD = 8'hEB,
  parameter logic [7:0]  PSRAM_WR_CMD = 8'h38
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [23:0] f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [23:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        latch,
  output logic        sclk,
  output logic [3:0]  dq_out,
  output logic [3:0]  dq_oe,
  input  logic [3:0]  dq_in,
  output logic        busy
);

  typedef enum logic [3:0] {
    INIT_SETUP, INIT_LATCH, INIT_HOLD, IDLE,
    SEL_SETUP, SEL_LATCH, SEL_HOLD,
    CMD, ADDR, DUMMY, DATA,
    DESEL_SETUP, DESEL_LATCH, DESEL_HOLD, DONE
  } state_e;

  localparam logic [5:0] DUM_F = 6'(2 * DUMMY_FLASH);
  localparam logic [5:0] DUM_P = 6'(2 * DUMMY_PSRAM);

  state_e      state_q, state_d;
  logic [5:0]  cyc_q, cyc_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic        last_q, last_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rd_q, rd_d;

  logic        latch_q, latch_d;
  logic        sclk_q, sclk_d;
  logic [3:0]  dq_out_q, dq_out_d;
  logic [3:0]  dq_oe_q, dq_oe_d;
  logic        f_ack_q, f_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [15:0] f_rdata_q, f_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;

  logic [5:0]  dum_n;
  logic [7:0]  op;

  function automatic logic [3:0] nib24(
    input logic [23:0] v,
    input logic [2:0]  k
  );
    logic [3:0] n;
    n = '0;
    unique case (k)
      3'd0:    n = v[23:20];
      3'd1:    n = v[19:16];
      3'd2:    n = v[15:12];
      3'd3:    n = v[11:8];
      3'd4:    n = v[7:4];
      3'd5:    n = v[3:0];
      default: n = '0;
    endcase
    return n;
  endfunction

  assign dum_n = sel_q ? (we_q ? 6'd0 : DUM_P) : DUM_F;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    unique case (state_q)
      INIT_SETUP:  state_d = INIT_LATCH;
      INIT_LATCH:  state_d = INIT_HOLD;
      INIT_HOLD:   state_d = IDLE;
      IDLE: begin
        if (f_req || d_req) begin
          // both pending: grant the port that did not win last time
          sel_d   = (f_req && d_req) ? ~last_q : d_req;
          we_d    = sel_d & d_we;
          addr_d  = sel_d ? d_addr : f_addr;
          wdata_d = d_wdata;
          last_d  = sel_d;
          state_d = SEL_SETUP;
        end
      end
      SEL_SETUP:   state_d = SEL_LATCH;
      SEL_LATCH:   state_d = SEL_HOLD;
      SEL_HOLD:    state_d = CMD;
      CMD: begin
        if (cyc_q == 6'd15) state_d = ADDR;
      end
      ADDR: begin
        if (cyc_q == 6'd11)
          state_d = (dum_n == 6'd0) ? DATA : DUMMY;
      end
      DUMMY: begin
        if (cyc_q == dum_n - 6'd1) state_d = DATA;
      end
      DATA: begin
        if (cyc_q[0] && !we_q) rd_d = {rd_q[11:0], dq_in};
        if (cyc_q == 6'd7) state_d = DESEL_SETUP;
      end
      DESEL_SETUP: state_d = DESEL_LATCH;
      DESEL_LATCH: state_d = DESEL_HOLD;
      DESEL_HOLD:  state_d = DONE;
      DONE:        state_d = IDLE;
      default:     state_d = INIT_SETUP;
    endcase
    cyc_d = (state_d == state_q) ? cyc_q + 6'd1 : 6'd0;
  end

  // Outputs are registered from next-state values so they track state_q
  // cycle for cycle while still reading as zero during reset.
  always_comb begin
    latch_d   = 1'b0;
    sclk_d    = 1'b0;
    dq_out_d  = '0;
    dq_oe_d   = '0;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    busy_d    = (state_d != IDLE);
    op = sel_d ? (we_d ? PSRAM_WR_CMD : PSRAM_RD_CMD) : FLASH_RD_CMD;
    unique case (state_d)
      INIT_SETUP, INIT_LATCH, INIT_HOLD,
      DESEL_SETUP, DESEL_LATCH, DESEL_HOLD: begin
        dq_oe_d  = 4'b0110;
        dq_out_d = 4'b0110;
        latch_d  = (state_d == INIT_LATCH) || (state_d == DESEL_LATCH);
      end
      SEL_SETUP, SEL_LATCH, SEL_HOLD: begin
        dq_oe_d  = 4'b0110;
        dq_out_d = {1'b0, ~sel_d, sel_d, 1'b0};
        latch_d  = (state_d == SEL_LATCH);
      end
      CMD: begin
        sclk_d      = cyc_d[0];
        dq_oe_d     = 4'b0001;
        dq_out_d[0] = op[~cyc_d[3:1]];
      end
      ADDR: begin
        sclk_d   = cyc_d[0];
        dq_oe_d  = 4'b1111;
        dq_out_d = nib24(addr_d, cyc_d[3:1]);
      end
      DUMMY: sclk_d = cyc_d[0];
      DATA: begin
        sclk_d = cyc_d[0];
        if (we_d) begin
          dq_oe_d  = 4'b1111;
          dq_out_d = wdata_d[{~cyc_d[2:1], 2'b00} +: 4];
        end
      end
      DONE: begin
        f_ack_d = ~sel_d;
        d_ack_d = sel_d;
        if (!sel_d) f_rdata_d = rd_d;
        else if (!we_d) d_rdata_d = rd_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT_SETUP;
      cyc_q     <= '0;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      latch_q   <= 1'b0;
      sclk_q    <= 1'b0;
      dq_out_q  <= '0;
      dq_oe_q   <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      latch_q   <= latch_d;
      sclk_q    <= sclk_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign latch   = latch_q;
  assign sclk    = sclk_q;
  assign dq_out  = dq_out_q;
  assign dq_oe   = dq_oe_q;
  assign f_ack   = f_ack_q;
  assign d_ack   = d_ack_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_lisa_qspi_arb.sv
// tb_lisa_qspi_arb: directed bench with a CE-latch + flash/PSRAM device model.
// Devices react to sclk rises; expected values are hand-derived constants.
module tb_lisa_qspi_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [23:0] f_addr = '0;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [23:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        latch;
  logic        sclk;
  logic [3:0]  dq_out;
  logic [3:0]  dq_oe;
  logic [3:0]  dq_in = '0;
  logic        busy;

  lisa_qspi_arb dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .latch(latch), .sclk(sclk), .dq_out(dq_out), .dq_oe(dq_oe),
    .dq_in(dq_in), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- device / board model ----------------
  logic [1:0]  m_ce;
  logic [1:0]  m_ce_first;
  logic [1:0]  m_ce_last;
  logic [7:0]  m_cmd;
  logic [23:0] m_addr;
  logic [15:0] m_wd;
  logic [15:0] m_rd;
  logic        m_sclk_prev = 1'b0;
  int          m_n = 0;
  int          m_d = 0;
  int          inv_bad = 0;
  logic [15:0] psram [logic [23:0]];
  logic [2:0]  ack_log [$];

  function automatic logic [15:0] flash_word(input logic [23:0] a);
    return 16'hA53C ^ a[15:0] ^ 16'h0100 ^ {8'h00, a[23:16]};
  endfunction

  always @(negedge clk) begin
    if (latch && (sclk || dq_oe[0] || dq_oe[3])) inv_bad++;
    if (f_ack || d_ack) ack_log.push_back({d_ack, m_ce_first});
    if (latch) begin
      m_ce = dq_out[2:1];
      m_n  = 0;
    end else if (sclk && !m_sclk_prev) begin
      m_n++;
      if (m_n == 1) m_ce_first = m_ce;
      m_ce_last = m_ce;
      if (m_n <= 8) m_cmd = {m_cmd[6:0], dq_out[0]};
      else if (m_n <= 14) m_addr = {m_addr[19:0], dq_out};
      if (m_n == 8) m_d = (m_ce == 2'b01 && m_cmd == 8'h38) ? 0 : 6;
      if (m_n == 14) begin
        if (m_ce == 2'b10) m_rd = flash_word(m_addr);
        else m_rd = psram.exists(m_addr) ? psram[m_addr] : 16'h0000;
      end
      if (m_n > 14 + m_d && m_n <= 18 + m_d) begin
        if (m_cmd == 8'h38) begin
          m_wd = {m_wd[11:0], dq_out};
          if (m_n == 18 + m_d) psram[m_addr] = m_wd;
        end else begin
          dq_in = m_rd[15:12];
          m_rd  = m_rd << 4;
        end
      end
    end
    m_sclk_prev = sclk;
  end

  // one transaction; returns the ack cycle (grant cycle = 0) or -1
  task automatic txn(input bit dport, input bit we, input logic [23:0] a,
                     input logic [15:0] wd, output int lat,
                     output logic [15:0] rd);
    lat = -1;
    rd  = 'x;
    if (dport) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = a;
    end
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk); #1;
      if (dport ? d_ack : f_ack) begin
        lat = c;
        rd  = dport ? d_rdata : f_rdata;
        break;
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [15:0] rd;
  int          nlat;
  int          latch_at;
  int          nack;
  int          last_c;
  int          acks_before;

  initial begin
    // reset state
    #22;
    chk("reset_outs", {latch, sclk, dq_out, dq_oe, f_ack, d_ack, busy},
        {1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1});
    chk("reset_rdata", {f_rdata, d_rdata}, 32'h0);

    // INIT deselect sequence
    @(negedge clk); rst_n = 1'b1;
    nlat = 0; latch_at = -1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (latch) begin
        nlat++;
        latch_at = c;
        chk("init_ce", {dq_out[2:1], dq_oe}, {2'b11, 4'b0110});
      end
      if (c == 2) chk("init_busy_c2", busy, 1'b1);
      if (c == 3) chk("idle_busy_c3", busy, 1'b0);
    end
    chk("init_latch_count", nlat, 1);
    chk("init_latch_cycle", latch_at, 1);

    // fetch
    txn(1'b0, 1'b0, 24'h000100, 16'h0, lat, rd);
    chk("fetch_lat", 32'(lat), 55);
    chk("fetch_rdata", rd, 16'hA53C);
    chk("fetch_cmd", m_cmd, 8'hEB);
    chk("fetch_addr", m_addr, 24'h000100);
    chk("fetch_ce", {m_ce_first, m_ce_last}, {2'b10, 2'b10});
    chk("fetch_ce_after", m_ce, 2'b11);

    // PSRAM write
    txn(1'b1, 1'b1, 24'h001234, 16'hBEEF, lat, rd);
    chk("wr_lat", 32'(lat), 43);
    chk("wr_cmd", m_cmd, 8'h38);
    chk("wr_ce", {m_ce_first, m_ce_last}, {2'b01, 2'b01});
    chk("wr_mem", psram.exists(24'h001234) ? psram[24'h001234] : 16'h0,
        16'hBEEF);
    chk("wr_ce_after", m_ce, 2'b11);

    // PSRAM read back
    txn(1'b1, 1'b0, 24'h001234, 16'h0, lat, rd);
    chk("rd_lat", 32'(lat), 55);
    chk("rd_rdata", rd, 16'hBEEF);
    chk("rd_cmd", m_cmd, 8'hEB);
    chk("rd_ce", {m_ce_first, m_ce_last}, {2'b01, 2'b01});

    // both ports together, held: F, D, F, D
    ack_log.delete();
    f_addr = 24'h000100; d_addr = 24'h001234; d_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    nack = 0; last_c = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (f_ack || d_ack) begin
        nack++;
        if (nack == 4) begin
          last_c = c;
          f_req = 1'b0; d_req = 1'b0;
          break;
        end
      end
    end
    @(posedge clk); #1;
    chk("rr_ack_count", ack_log.size(), 4);
    chk("rr_last_cycle", last_c, 223);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), ack_log[i],
          (i % 2 == 1) ? 3'b101 : 3'b010);
    end
    chk("rr_rdata", {f_rdata, d_rdata}, {16'hA53C, 16'hBEEF});

    // reset in the middle of ADDR
    acks_before = ack_log.size();
    f_addr = 24'h000100; f_req = 1'b1;
    repeat (24) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; f_req = 1'b0; #1;
    chk("midrst_outs", {latch, sclk, dq_out, dq_oe, f_ack, d_ack, busy},
        {1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1});
    chk("midrst_rdata", {f_rdata, d_rdata}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nlat = 0; latch_at = -1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (latch) begin nlat++; latch_at = c; end
    end
    chk("midrst_latch_cycle", latch_at, 1);
    chk("midrst_no_ack", ack_log.size() - acks_before, 0);
    chk("midrst_ce", m_ce, 2'b11);

    // fetch after reset
    txn(1'b0, 1'b0, 24'h000200, 16'h0, lat, rd);
    chk("fetch2_lat", 32'(lat), 55);
    chk("fetch2_rdata", rd, 16'hA63C);
    chk("fetch2_addr", m_addr, 24'h000200);
    chk("fetch2_ce", m_ce_first, 2'b10);

    chk("latch_invariant", inv_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
